pass_sequencer: RTL and testbench
=================================

Name: pass_sequencer

Overview:
- Upstream stage of the per-pass PE-array controller; acts as that controller's "higher-level controller".
- Streams the eight XID/YID tables from a host valid/ready channel into the controller's ID write port.
- Then runs N passes back-to-back. For each pass it drives op_config start, bias_ipsum_sel and per-pass base addresses, and waits for the controller's done.
- Reports completion to the host with a one-cycle pulse.

Parameters:
- NUMS_PE_ROW, 6, PE array rows (YID table depth).
- NUMS_PE_COL, 8, PE array columns; XID table depth = NUMS_PE_ROW*NUMS_PE_COL.
- XID_BITS, 5, XID width.
- YID_BITS, 3, YID width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- seq_start  in  1  one-cycle request; sampled only in IDLE
- seq_load_id  in  1  sampled with seq_start; 1 = reload ID tables first
- seq_num_passes  in  8  pass count, sampled with seq_start
- cfg_op_config  in  32  op config; bit0 ignored and replaced by the internal start bit
- cfg_filter_base  in  32  filter base address for pass 0
- cfg_filter_stride  in  32  filter base increment per pass
- cfg_ifmap_base  in  32  ifmap base address, constant over passes
- cfg_bias_base  in  32  bias base address, constant
- cfg_opsum_base  in  32  opsum base address, constant (accumulated in place)
- id_valid  in  1  host ID beat valid
- id_ready  out  1  host ID beat ready
- id_data  in  XID_BITS  host ID beat
- op_config  out  32  to controller
- bias_ipsum_sel  out  1  to controller; 1 on pass 0 only
- filter_baseaddr  out  32  to controller
- ifmap_baseaddr  out  32  to controller
- bias_baseaddr  out  32  to controller
- opsum_baseaddr  out  32  to controller
- ctrl_done  in  1  controller done (level)
- ctrl_ID_wen  out  1  ID write enable
- ctrl_ID_wsel  out  3  table select: 0-3 XID ifmap/filter/ipsum/opsum, 4-7 YID same order
- ctrl_ID_widx  out  6  entry index
- ctrl_ID_wdata  out  XID_BITS  entry data
- seq_busy  out  1  high outside IDLE
- seq_done  out  1  one-cycle completion pulse
- pass_idx  out  8  current pass number

Behaviour:
- All outputs registered. Reset values: every output 0, state IDLE.
- Reset asserted mid-operation returns the block to IDLE at once; no partial completion pulse.
- States: IDLE, LOAD_ID, START, WAIT_DONE, RELEASE, FINISH.
- IDLE:
  - On seq_start, latch num_passes, cfg_* and load_id.
  - Go to LOAD_ID if load_id=1, otherwise START.
  - If num_passes=0, go straight to FINISH, skipping the ID load.
  - seq_start outside IDLE is ignored.
- LOAD_ID:
  - id_ready=1. Each accepted beat (id_valid&id_ready) drives ctrl_ID_wen=1 on the next cycle, with the wsel/widx of that beat and wdata=id_data.
  - Order: wsel 0..3, each idx 0..NUMS_PE_ROW*NUMS_PE_COL-1; then wsel 4..7, each idx 0..NUMS_PE_ROW-1. Default total is 216 beats.
  - Backpressure-free toward the controller. Gaps in id_valid insert idle cycles with wen=0.
  - After the last beat's write, go to START. id_ready drops the cycle after the last accept.
- START:
  - op_config = cfg_op_config with bit0=1.
  - bias_ipsum_sel = (pass_idx==0).
  - filter_baseaddr = cfg_filter_base + pass_idx*cfg_filter_stride, mod 2^32.
  - Other base outputs equal the latched cfg values.
  - Next cycle go to WAIT_DONE.
- WAIT_DONE:
  - Hold bit0=1 until ctrl_done=1.
  - Then clear bit0 and go to RELEASE.
- RELEASE:
  - Wait until ctrl_done=0, i.e. the controller has returned to IDLE.
  - If pass_idx==num_passes-1, go to FINISH.
  - Otherwise increment pass_idx, update filter_baseaddr and go to START.
  - Base outputs change only in RELEASE/IDLE, never while bit0=1.
- FINISH:
  - seq_done=1 for exactly one cycle, then IDLE.
  - pass_idx holds its last value until the next seq_start clears it.
- seq_busy = (state != IDLE).
- pass_idx wraps never: 8-bit, with the maximum of 255 passes bounded by num_passes.

Optional Feature:
- PASS_SEQ_PERF_EN defined: adds output perf_cycles (32 bits).
  - Cleared on seq_start.
  - Increments every cycle the state is in WAIT_DONE; saturates at 0xFFFFFFFF.
  - Holds after FINISH.
- Undefined: port and counter are absent.

Test Plan:
- Reset mid-LOAD_ID (after 50 beats) -> next cycle all outputs 0 and seq_busy=0. A subsequent start reloads from wsel 0 idx 0.
- seq_start, load_id=1, num_passes=1, host sends 216 beats with data=beat index mod 32 -> wen pulses carry wsel0 idx0..47, ..., wsel7 idx0..5 with matching data. Then op_config bit0=1, bias_ipsum_sel=1.
- num_passes=3, load_id=0, filter_base=0x100, stride=0x40, controller model asserts done 20 cycles after start and clears it 1 cycle after bit0 drops:
  - filter_baseaddr goes 0x100, 0x140, 0x180.
  - bias_ipsum_sel goes 1, 0, 0.
  - Exactly one seq_done pulse after the third done clears.
- num_passes=0 -> seq_done pulses 2 cycles after seq_start; op_config bit0 never set and no wen.
- ctrl_done held high 5 extra cycles after bit0 drops -> no next START until done low. seq_start pulsed while busy is ignored.
- With PASS_SEQ_PERF_EN and done at 20 cycles per pass over 2 passes -> perf_cycles=40 at seq_done.

Source files
------------

// File: rtl/pass_sequencer.sv
// pass_sequencer: upstream sequencer for the per-pass PE-array controller.
// Streams the eight XID/YID tables from the host into the controller's ID
// write port, then runs N passes back-to-back, driving start/base addresses
// for each pass and waiting on ctrl_done. Completion is a one-cycle seq_done.
// Optional build macro PASS_SEQ_PERF_EN adds the perf_cycles output (cycles
// spent waiting on the controller, saturating).
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for seq_start
// LOAD_ID   | id_ready high, each accepted beat written to the ID port
// START     | base addresses settled; start bit (op_config[0]) rises on exit
// WAIT_DONE | start bit held high until ctrl_done
// RELEASE   | start bit low; waiting for ctrl_done to drop
// FINISH    | run complete; seq_done pulses on exit
module pass_sequencer #(
    parameter int NUMS_PE_ROW = 6,
    parameter int NUMS_PE_COL = 8,
    parameter int XID_BITS    = 5,
    parameter int YID_BITS    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                seq_start,
    input  logic                seq_load_id,
    input  logic [7:0]          seq_num_passes,
    input  logic [31:0]         cfg_op_config,
    input  logic [31:0]         cfg_filter_base,
    input  logic [31:0]         cfg_filter_stride,
    input  logic [31:0]         cfg_ifmap_base,
    input  logic [31:0]         cfg_bias_base,
    input  logic [31:0]         cfg_opsum_base,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [XID_BITS-1:0] id_data,
    output logic [31:0]         op_config,
    output logic                bias_ipsum_sel,
    output logic [31:0]         filter_baseaddr,
    output logic [31:0]         ifmap_baseaddr,
    output logic [31:0]         bias_baseaddr,
    output logic [31:0]         opsum_baseaddr,
    input  logic                ctrl_done,
    output logic                ctrl_ID_wen,
    output logic [2:0]          ctrl_ID_wsel,
    output logic [5:0]          ctrl_ID_widx,
    output logic [XID_BITS-1:0] ctrl_ID_wdata,
    output logic                seq_busy,
    output logic                seq_done,
    output logic [7:0]          pass_idx
`ifdef PASS_SEQ_PERF_EN
    ,
    output logic [31:0]         perf_cycles
`endif
);

    localparam logic [5:0] XID_LAST = 6'(NUMS_PE_ROW * NUMS_PE_COL - 1);
    localparam logic [5:0] YID_LAST = 6'(NUMS_PE_ROW - 1);

    // YID entries travel on the XID-wide data path, so a YID wider than an
    // XID has nowhere to go; such a configuration is left empty here.
    if (YID_BITS > XID_BITS) begin : g_yid_wider_than_xid
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_ID   = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RELEASE   = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]          r_num_passes;
    logic [31:1]         r_op_cfg;
    logic [31:0]         r_filter_stride;
    logic [7:0]          r_pass_idx;
    logic [31:0]         r_op_config;
    logic                r_bias_sel;
    logic [31:0]         r_filter_base;
    logic [31:0]         r_ifmap_base;
    logic [31:0]         r_bias_base;
    logic [31:0]         r_opsum_base;
    logic [2:0]          r_cnt_sel;
    logic [5:0]          r_cnt_idx;
    logic                r_id_ready;
    logic                r_wen;
    logic [2:0]          r_wsel;
    logic [5:0]          r_widx;
    logic [XID_BITS-1:0] r_wdata;
    logic                r_busy;
    logic                r_done;

    logic w_start;
    logic w_accept;
    logic w_idx_last;
    logic w_load_last;
    logic w_last_pass;
    logic w_next_pass;
    logic w_unused;

    // The start bit is generated internally, so the host's bit0 is dropped.
    assign w_unused    = cfg_op_config[0];

    assign w_start     = (r_state == S_IDLE) && seq_start;
    assign w_accept    = (r_state == S_LOAD_ID) && id_valid && r_id_ready;
    assign w_idx_last  = r_cnt_sel[2] ? (r_cnt_idx == YID_LAST) : (r_cnt_idx == XID_LAST);
    assign w_load_last = w_idx_last && (r_cnt_sel == 3'd7);
    assign w_last_pass = (r_pass_idx == r_num_passes - 8'd1);
    assign w_next_pass = (r_state == S_RELEASE) && !ctrl_done && !w_last_pass;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (seq_start) begin
                    if (seq_num_passes == 8'd0) w_state_nxt = S_FINISH;
                    else if (seq_load_id)       w_state_nxt = S_LOAD_ID;
                    else                        w_state_nxt = S_START;
                end
            end
            S_LOAD_ID: begin
                if (w_accept && w_load_last) w_state_nxt = S_START;
            end
            S_START: w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (ctrl_done) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!ctrl_done) w_state_nxt = w_last_pass ? S_FINISH : S_START;
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Run configuration latch, pass counter and base addresses; bases move
    // only on a new run or between passes, a cycle before the start bit rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_passes    <= '0;
            r_op_cfg        <= '0;
            r_filter_stride <= '0;
            r_pass_idx      <= '0;
            r_bias_sel      <= 1'b0;
            r_filter_base   <= '0;
            r_ifmap_base    <= '0;
            r_bias_base     <= '0;
            r_opsum_base    <= '0;
        end else if (w_start) begin
            r_num_passes    <= seq_num_passes;
            r_op_cfg        <= cfg_op_config[31:1];
            r_filter_stride <= cfg_filter_stride;
            r_pass_idx      <= '0;
            r_bias_sel      <= (seq_num_passes != 8'd0);
            r_filter_base   <= cfg_filter_base;
            r_ifmap_base    <= cfg_ifmap_base;
            r_bias_base     <= cfg_bias_base;
            r_opsum_base    <= cfg_opsum_base;
        end else if (w_next_pass) begin
            r_pass_idx      <= r_pass_idx + 8'd1;
            r_bias_sel      <= 1'b0;
            r_filter_base   <= r_filter_base + r_filter_stride;
        end
    end

    // Controller op_config: start bit raised leaving START, cleared on done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_config <= '0;
        end else if (r_state == S_START) begin
            r_op_config <= {r_op_cfg, 1'b1};
        end else if ((r_state == S_WAIT_DONE) && ctrl_done) begin
            r_op_config[0] <= 1'b0;
        end
    end

    // ID table streaming: one registered write per accepted host beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_sel  <= '0;
            r_cnt_idx  <= '0;
            r_id_ready <= 1'b0;
            r_wen      <= 1'b0;
            r_wsel     <= '0;
            r_widx     <= '0;
            r_wdata    <= '0;
        end else begin
            r_id_ready <= (w_state_nxt == S_LOAD_ID);
            r_wen      <= w_accept;
            if (w_accept) begin
                r_wsel  <= r_cnt_sel;
                r_widx  <= r_cnt_idx;
                r_wdata <= id_data;
            end
            if (w_start) begin
                r_cnt_sel <= '0;
                r_cnt_idx <= '0;
            end else if (w_accept) begin
                if (w_idx_last) begin
                    r_cnt_idx <= '0;
                    r_cnt_sel <= r_cnt_sel + 3'd1;
                end else begin
                    r_cnt_idx <= r_cnt_idx + 6'd1;
                end
            end
        end
    end

    // Status: busy mirrors the state register, done pulses leaving FINISH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (r_state == S_FINISH);
        end
    end

`ifdef PASS_SEQ_PERF_EN
    logic [31:0] r_perf_cycles;

    // Cycles spent waiting on the controller, cleared per run, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cycles <= '0;
        end else if (w_start) begin
            r_perf_cycles <= '0;
        end else if ((r_state == S_WAIT_DONE) && (r_perf_cycles != 32'hFFFF_FFFF)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
`endif

    assign id_ready        = r_id_ready;
    assign op_config       = r_op_config;
    assign bias_ipsum_sel  = r_bias_sel;
    assign filter_baseaddr = r_filter_base;
    assign ifmap_baseaddr  = r_ifmap_base;
    assign bias_baseaddr   = r_bias_base;
    assign opsum_baseaddr  = r_opsum_base;
    assign ctrl_ID_wen     = r_wen;
    assign ctrl_ID_wsel    = r_wsel;
    assign ctrl_ID_widx    = r_widx;
    assign ctrl_ID_wdata   = r_wdata;
    assign seq_busy        = r_busy;
    assign seq_done        = r_done;
    assign pass_idx        = r_pass_idx;

endmodule

// File: tb/tb_pass_sequencer.sv
// tb_pass_sequencer: scoreboard bench for pass_sequencer. Expected ID writes,
// per-pass start settings and completions are queued when stimulus is driven
// and checked when the DUT produces them. A small controller model answers
// the start bit with ctrl_done after a programmable delay.
`timescale 1ns/1ps
module tb_pass_sequencer;

    localparam int XB = 5;
    localparam int TOTAL_BEATS = 216;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          seq_start, seq_load_id;
    logic [7:0]    seq_num_passes;
    logic [31:0]   cfg_op_config, cfg_filter_base, cfg_filter_stride;
    logic [31:0]   cfg_ifmap_base, cfg_bias_base, cfg_opsum_base;
    logic          id_valid, id_ready;
    logic [XB-1:0] id_data;
    logic [31:0]   op_config, filter_baseaddr, ifmap_baseaddr, bias_baseaddr, opsum_baseaddr;
    logic          bias_ipsum_sel;
    logic          ctrl_done;
    logic          ctrl_ID_wen;
    logic [2:0]    ctrl_ID_wsel;
    logic [5:0]    ctrl_ID_widx;
    logic [XB-1:0] ctrl_ID_wdata;
    logic          seq_busy, seq_done;
    logic [7:0]    pass_idx;
`ifdef PASS_SEQ_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    pass_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .seq_start(seq_start), .seq_load_id(seq_load_id), .seq_num_passes(seq_num_passes),
        .cfg_op_config(cfg_op_config), .cfg_filter_base(cfg_filter_base),
        .cfg_filter_stride(cfg_filter_stride), .cfg_ifmap_base(cfg_ifmap_base),
        .cfg_bias_base(cfg_bias_base), .cfg_opsum_base(cfg_opsum_base),
        .id_valid(id_valid), .id_ready(id_ready), .id_data(id_data),
        .op_config(op_config), .bias_ipsum_sel(bias_ipsum_sel),
        .filter_baseaddr(filter_baseaddr), .ifmap_baseaddr(ifmap_baseaddr),
        .bias_baseaddr(bias_baseaddr), .opsum_baseaddr(opsum_baseaddr),
        .ctrl_done(ctrl_done), .ctrl_ID_wen(ctrl_ID_wen), .ctrl_ID_wsel(ctrl_ID_wsel),
        .ctrl_ID_widx(ctrl_ID_widx), .ctrl_ID_wdata(ctrl_ID_wdata),
        .seq_busy(seq_busy), .seq_done(seq_done), .pass_idx(pass_idx)
`ifdef PASS_SEQ_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [13:0] id_q[$];
    logic [31:0] filt_q[$];
    logic        sel_q[$];
    logic [7:0]  pidx_q[$];
    logic [7:0]  done_q[$];

    logic [31:0] exp_op, exp_ifmap, exp_bias, exp_opsum;
    int done_delay = 20;
    int done_extra = 0;
    int done_cnt   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_op"},     op_config, 0);
        chk({tag, "_filt"},   filter_baseaddr, 0);
        chk({tag, "_ifmap"},  ifmap_baseaddr, 0);
        chk({tag, "_bias"},   bias_baseaddr, 0);
        chk({tag, "_opsum"},  opsum_baseaddr, 0);
        chk({tag, "_ctl"}, {ctrl_ID_wen, ctrl_ID_wsel, ctrl_ID_widx, ctrl_ID_wdata,
                            id_ready, seq_busy, seq_done, bias_ipsum_sel, pass_idx}, 0);
    endtask

    function automatic logic [13:0] id_expect(input int b);
        logic [2:0] s;
        logic [5:0] x;
        if (b < 192) begin
            s = 3'(b / 48);
            x = 6'(b % 48);
        end else begin
            s = 3'(4 + (b - 192) / 6);
            x = 6'((b - 192) % 6);
        end
        return {s, x, 5'(b % 32)};
    endfunction

    task automatic flush_queues();
        id_q.delete(); filt_q.delete(); sel_q.delete(); pidx_q.delete(); done_q.delete();
    endtask

    task automatic start_seq(input bit load, input logic [7:0] num, input logic [31:0] op,
                             input logic [31:0] fbase, input logic [31:0] fstride,
                             input logic [31:0] ifm, input logic [31:0] bias, input logic [31:0] osum);
        @(negedge clk);
        seq_start = 1'b1; seq_load_id = load; seq_num_passes = num;
        cfg_op_config = op; cfg_filter_base = fbase; cfg_filter_stride = fstride;
        cfg_ifmap_base = ifm; cfg_bias_base = bias; cfg_opsum_base = osum;
        exp_op = op; exp_ifmap = ifm; exp_bias = bias; exp_opsum = osum;
        for (int i = 0; i < int'(num); i++) begin
            filt_q.push_back(fbase + 32'(i) * fstride);
            sel_q.push_back(i == 0);
            pidx_q.push_back(8'(i));
        end
        done_q.push_back((num == 8'd0) ? 8'd0 : num - 8'd1);
        @(negedge clk);
        seq_start = 1'b0;
    endtask

    task automatic send_ids(input int n_stop, input bit gaps);
        int beat = 0;
        int budget = 0;
        while (beat < n_stop && budget < 4000) begin
            @(negedge clk);
            budget++;
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                id_valid = 1'b0;
            end else begin
                id_valid = 1'b1;
                id_data  = 5'(beat % 32);
            end
            if (id_valid && id_ready) begin
                id_q.push_back(id_expect(beat));
                beat++;
            end
        end
        @(negedge clk);
        id_valid = 1'b0;
        chk("id_beats_accepted", beat, n_stop);
        if (n_stop == TOTAL_BEATS) chk("id_ready_drop", id_ready, 0);
    endtask

    task automatic wait_done(input int budget);
        int start_cnt = done_cnt;
        int n = 0;
        while (done_cnt == start_cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", done_cnt != start_cnt, 1);
    endtask

    // Controller model: done after done_delay cycles of start, released
    // done_extra cycles after the start bit drops
    initial begin
        int hi_cnt = 0;
        int lo_cnt = 0;
        ctrl_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ctrl_done = 1'b0; hi_cnt = 0; lo_cnt = 0;
            end else if (!ctrl_done) begin
                lo_cnt = 0;
                if (op_config[0]) begin
                    hi_cnt++;
                    if (hi_cnt >= done_delay) ctrl_done = 1'b1;
                end else begin
                    hi_cnt = 0;
                end
            end else begin
                hi_cnt = 0;
                if (!op_config[0]) begin
                    lo_cnt++;
                    if (lo_cnt > done_extra) ctrl_done = 1'b0;
                end
            end
        end
    end

    // Output monitor / scoreboard consumer
    initial begin
        int cyc = 0;
        int fall_cyc = 0;
        logic prev_bit0 = 1'b0;
        logic [31:0] cur_filter = '0;
        logic [31:0] ef;
        logic        es;
        logic [7:0]  ep;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_bit0 = 1'b0;
                continue;
            end
            cyc++;
            if (ctrl_ID_wen) begin
                chk("wen_expected", id_q.size() != 0, 1);
                if (id_q.size() != 0)
                    chk("id_write", {ctrl_ID_wsel, ctrl_ID_widx, ctrl_ID_wdata}, id_q.pop_front());
            end
            if (op_config[0] && !prev_bit0) begin
                chk("start_expected", filt_q.size() != 0, 1);
                if (filt_q.size() != 0) begin
                    ef = filt_q.pop_front(); es = sel_q.pop_front(); ep = pidx_q.pop_front();
                    chk("filter_base", filter_baseaddr, ef);
                    chk("bias_sel", bias_ipsum_sel, es);
                    chk("pass_idx", pass_idx, ep);
                    chk("op_config", op_config, exp_op | 32'd1);
                    chk("ifmap_base", ifmap_baseaddr, exp_ifmap);
                    chk("bias_base", bias_baseaddr, exp_bias);
                    chk("opsum_base", opsum_baseaddr, exp_opsum);
                    if (ep != 8'd0) chk("restart_gap", cyc - fall_cyc, done_extra + 2);
                end
                chk("ids_before_start", id_q.size(), 0);
                chk("done_low_at_start", ctrl_done, 0);
                cur_filter = filter_baseaddr;
            end else if (op_config[0]) begin
                chk("filter_stable", filter_baseaddr, cur_filter);
            end
            if (!op_config[0] && prev_bit0) fall_cyc = cyc;
            prev_bit0 = op_config[0];
            if (seq_done) begin
                done_cnt++;
                chk("done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) chk("done_pass_idx", pass_idx, done_q.pop_front());
            end
        end
    end

    initial begin
        seq_start = 0; seq_load_id = 0; seq_num_passes = 0;
        cfg_op_config = 0; cfg_filter_base = 0; cfg_filter_stride = 0;
        cfg_ifmap_base = 0; cfg_bias_base = 0; cfg_opsum_base = 0;
        id_valid = 0; id_data = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of an ID load
        start_seq(1'b1, 8'd1, 32'hA5A5_0000, 32'h0000_2000, 32'h10,
                  32'h3000, 32'h4000, 32'h5000);
        send_ids(50, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk_idle_outputs("reset_mid_load");
        flush_queues();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full ID load with gaps, then one pass
        start_seq(1'b1, 8'd1, 32'h1234_5678, 32'h0000_1000, 32'h20,
                  32'h0001_0000, 32'h0002_0000, 32'h0003_0000);
        send_ids(TOTAL_BEATS, 1'b1);
        wait_done(2000);

        // Three passes, busy start ignored, cfg inputs changed after latch
        start_seq(1'b0, 8'd3, 32'hCAFE_0001, 32'h100, 32'h40,
                  32'h0000_0800, 32'h0000_0900, 32'h0000_0A00);
        cfg_op_config = 32'hFFFF_FFFE; cfg_filter_base = 32'hDEAD_0000;
        cfg_filter_stride = 32'h1; cfg_ifmap_base = 32'h1111_1111;
        cfg_bias_base = 32'h2222_2222; cfg_opsum_base = 32'h3333_3333;
        repeat (10) @(negedge clk);
        seq_num_passes = 8'd9; seq_load_id = 1'b1; seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
        wait_done(1000);
        repeat (5) @(negedge clk);
        chk("pass_idx_hold", pass_idx, 2);
        chk("busy_after_run", seq_busy, 0);
        chk("passes_consumed", filt_q.size(), 0);

        // Done held after start drops; filter base wraps past 2^32
        done_extra = 5;
        start_seq(1'b0, 8'd2, 32'h0, 32'hFFFF_FFE0, 32'h20,
                  32'h44, 32'h55, 32'h66);
        wait_done(1000);
        done_extra = 0;
        repeat (3) @(negedge clk);

        // Zero passes: straight to completion
        start_seq(1'b1, 8'd0, 32'h7, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1);
        chk("n0_busy", seq_busy, 1);
        chk("n0_done_early", seq_done, 0);
        @(negedge clk);
        chk("n0_done", seq_done, 1);
        chk("n0_idle", id_ready, 0);
        @(negedge clk);
        chk("n0_done_pulse", seq_done, 0);
        chk("n0_busy_clear", seq_busy, 0);
        chk("n0_no_start", op_config[0], 0);
        repeat (3) @(negedge clk);

`ifdef PASS_SEQ_PERF_EN
        start_seq(1'b0, 8'd2, 32'h0, 32'h200, 32'h8, 32'h9, 32'hA, 32'hB);
        chk("perf_clear", perf_cycles, 0);
        wait_done(1000);
        chk("perf_cycles", perf_cycles, 40);
        repeat (3) @(negedge clk);
        chk("perf_hold", perf_cycles, 40);
`endif

        chk("queues_drained", id_q.size() + filt_q.size() + done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
